// File: rtl/prefix_sum_pipe_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone carry resolver.
package prefix_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prefix_sum_pipe_if.sv
// Handshake bundle for prefix_sum_pipe; ovf is present only when PREFIX_SUM_OVF_EN is defined.
interface prefix_sum_pipe_if
    import prefix_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] h_in;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef PREFIX_SUM_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, g_in, p_in, h_in, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, g_in, p_in, h_in, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, g_in, p_in, h_in, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, g_in, p_in, h_in, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface

// File: rtl/prefix_sum_pipe_cell.sv
// Kogge-Stone black cell; used as a gray cell by leaving p unconnected.
module prefix_cell
    import prefix_pkg::*;
(
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);
    gp_t hi;
    gp_t lo;
    gp_t res;

    assign hi    = {g_hi, p_hi};
    assign lo    = {g_lo, p_lo};
    assign res.g = hi.g | (hi.p & lo.g);
    assign res.p = hi.p & lo.p;
    assign g     = res.g;
    assign p     = res.p;

endmodule

// File: rtl/prefix_sum_pipe.sv
// Registered Kogge-Stone carry network turning per-bit g/p/h into sum/cout.
// Optional overflow output enabled by PREFIX_SUM_OVF_EN.
module prefix_sum_pipe
    import prefix_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    prefix_sum_pipe_if.slave bus
);
    localparam int LEVELS = clog2(WIDTH);
    localparam int NL     = (LEVELS > 0) ? LEVELS : 1;

    // index k = inputs seen by level k+1; index LEVELS feeds the sum stage
    logic [WIDTH-1:0] g_src   [LEVELS+1];
    logic [WIDTH-1:0] p_src   [LEVELS+1];
    logic [WIDTH-1:0] h_src   [LEVELS+1];
    logic             cin_src [LEVELS+1];
    logic             vld_src [LEVELS+1];

    logic [WIDTH-1:0] g_nxt [NL];
    logic [WIDTH-1:0] p_nxt [NL];

    logic [WIDTH-1:0] g_q   [NL];
    logic [WIDTH-1:0] p_q   [NL];
    logic [WIDTH-1:0] h_q   [NL];
    logic             cin_q [NL];
    logic             vld_q [NL];

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             stall;

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;

    assign stall        = out_valid_q && !bus.out_ready;
    assign bus.in_ready = !stall;

    // cin is folded into bit 0 so every group generate already includes it
    always_comb begin
        g_src[0]    = bus.g_in;
        g_src[0][0] = bus.g_in[0] | (bus.p_in[0] & bus.cin);
        p_src[0]    = bus.p_in;
        h_src[0]    = bus.h_in;
        cin_src[0]  = bus.cin;
        vld_src[0]  = bus.in_valid;
        for (int k = 1; k <= LEVELS; k++) begin
            g_src[k]   = g_q[k-1];
            p_src[k]   = p_q[k-1];
            h_src[k]   = h_q[k-1];
            cin_src[k] = cin_q[k-1];
            vld_src[k] = vld_q[k-1];
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int D = 1 << k;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_cell
                prefix_cell u_cell (
                    .g_hi (g_src[k][i]),
                    .p_hi (p_src[k][i]),
                    .g_lo (g_src[k][i-D]),
                    .p_lo (p_src[k][i-D]),
                    .g    (g_nxt[k][i]),
                    .p    (p_nxt[k][i])
                );
            end else begin : g_pass
                assign g_nxt[k][i] = g_src[k][i];
                assign p_nxt[k][i] = p_src[k][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NL; k++) begin
                g_q[k]   <= '0;
                p_q[k]   <= '0;
                h_q[k]   <= '0;
                cin_q[k] <= 1'b0;
                vld_q[k] <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < LEVELS; k++) begin
                g_q[k]   <= g_nxt[k];
                p_q[k]   <= p_nxt[k];
                h_q[k]   <= h_src[k];
                cin_q[k] <= cin_src[k];
                vld_q[k] <= vld_src[k];
            end
        end
    end

    always_comb begin
        carry    = '0;
        carry[0] = cin_src[LEVELS];
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = g_src[LEVELS][i-1];
        end
        sum_nxt  = h_src[LEVELS] ^ carry;
        cout_nxt = g_src[LEVELS][WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= vld_src[LEVELS];
            sum_q       <= sum_nxt;
            cout_q      <= cout_nxt;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

`ifdef PREFIX_SUM_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= carry[WIDTH-1] ^ cout_nxt;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_prefix_sum_pipe.sv
// Scoreboard bench for prefix_sum_pipe at WIDTH=8 (directed) and WIDTH=13 (random).
// Checks ovf as well when PREFIX_SUM_OVF_EN is defined.
module tb_prefix_sum_pipe;
    import prefix_pkg::*;

    localparam int W8  = 8;
    localparam int W13 = 13;
    localparam int N13 = 1500;

    logic clk = 1'b0;
    logic rst;
    logic rst13;

    always #5 clk = ~clk;

    prefix_sum_pipe_if #(.WIDTH(W8))  bus8  ();
    prefix_sum_pipe_if #(.WIDTH(W13)) bus13 ();

    prefix_sum_pipe #(.WIDTH(W8))  dut8  (.clk(clk), .rst(rst),   .bus(bus8));
    prefix_sum_pipe #(.WIDTH(W13)) dut13 (.clk(clk), .rst(rst13), .bus(bus13));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q8[$];
    exp_t q13[$];
    int   checks = 0;
    int   fails  = 0;
    int   got8   = 0;
    int   got13  = 0;
    bit   done13 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                   input logic c);
        exp_t        e;
        logic [16:0] full;
        logic [15:0] mask;
        mask   = 16'((17'd1 << w) - 17'd1);
        full   = {1'b0, x} + {1'b0, y} + {16'd0, c};
        e.sum  = full[15:0] & mask;
        e.cout = full[w];
        e.ovf  = (x[w-1] == y[w-1]) && (e.sum[w-1] != x[w-1]);
        return e;
    endfunction

    task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic c);
        bus8.g_in = x & y;
        bus8.p_in = x | y;
        bus8.h_in = x ^ y;
        bus8.cin  = c;
    endtask

    task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int t;
        t = 0;
        @(negedge clk);
        drive8(x, y, c);
        bus8.in_valid = 1'b1;
        #1;
        while (!bus8.in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (bus8.in_ready) begin
            q8.push_back(model(W8, {8'd0, x}, {8'd0, y}, c));
        end else begin
            checks++;
            fails++;
            $display("FAIL send8_timeout: in_ready stuck at 0 for %0d cycles", t);
        end
    endtask

    task automatic idle8();
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    task automatic drain8(input string name);
        int t;
        t = 0;
        while (q8.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        #3;
        chk(name, 32'(q8.size()), 32'd0);
    endtask

    // WIDTH=8 monitor: pops on every output transfer and checks stall hold
    initial begin : mon8
        logic       stalled;
        logic [7:0] hsum;
        logic       hcout;
        exp_t       e;
        stalled = 1'b0;
        hsum    = '0;
        hcout   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (stalled) begin
                chk("hold_valid8", 32'(bus8.out_valid), 32'd1);
                chk("hold_sum8", 32'(bus8.sum), 32'(hsum));
                chk("hold_cout8", 32'(bus8.cout), 32'(hcout));
            end
            stalled = bus8.out_valid && !bus8.out_ready && !rst;
            hsum    = bus8.sum;
            hcout   = bus8.cout;
            if (bus8.out_valid && bus8.out_ready && !rst) begin
                got8++;
                if (q8.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out8: sum 0x%0h with empty scoreboard", bus8.sum);
                end else begin
                    e = q8.pop_front();
                    chk("sum8", 32'(bus8.sum), 32'(e.sum[7:0]));
                    chk("cout8", 32'(bus8.cout), 32'(e.cout));
`ifdef PREFIX_SUM_OVF_EN
                    chk("ovf8", 32'(bus8.ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    initial begin : mon13
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus13.out_valid && bus13.out_ready && !rst13) begin
                got13++;
                if (q13.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out13: sum 0x%0h with empty scoreboard", bus13.sum);
                end else begin
                    e = q13.pop_front();
                    chk("sum13", 32'(bus13.sum), 32'(e.sum[12:0]));
                    chk("cout13", 32'(bus13.cout), 32'(e.cout));
`ifdef PREFIX_SUM_OVF_EN
                    chk("ovf13", 32'(bus13.ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    initial begin : drv13
        logic [12:0] x;
        logic [12:0] y;
        logic        c;
        bit          pend;
        int          sent;
        int          cyc;
        int          t;
        x = '0; y = '0; c = 1'b0; pend = 1'b0; sent = 0; cyc = 0; t = 0;
        rst13           = 1'b1;
        bus13.in_valid  = 1'b0;
        bus13.out_ready = 1'b0;
        bus13.g_in      = '0;
        bus13.p_in      = '0;
        bus13.h_in      = '0;
        bus13.cin       = 1'b0;
        repeat (3) @(negedge clk);
        rst13 = 1'b0;
        while (sent < N13 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            bus13.out_ready = ($urandom_range(0, 3) != 0);
            if (!pend && $urandom_range(0, 4) != 0) begin
                x    = 13'($urandom);
                y    = 13'($urandom);
                c    = 1'($urandom_range(0, 1));
                pend = 1'b1;
            end
            bus13.in_valid = pend;
            bus13.g_in     = x & y;
            bus13.p_in     = x | y;
            bus13.h_in     = x ^ y;
            bus13.cin      = c;
            #1;
            if (pend && bus13.in_ready) begin
                q13.push_back(model(W13, {3'd0, x}, {3'd0, y}, c));
                pend = 1'b0;
                sent++;
            end
        end
        @(negedge clk);
        bus13.in_valid  = 1'b0;
        bus13.out_ready = 1'b1;
        while (q13.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        #3;
        chk("drain13", 32'(q13.size()), 32'd0);
        chk("count13", 32'(got13), 32'(N13));
        done13 = 1'b1;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1);
    end

    initial begin : main
        logic [7:0] vx [6];
        logic [7:0] vy [6];
        int         lat;
        int         acc;
        int         base;
        int         t;

        vx = '{8'h12, 8'hF0, 8'hAA, 8'h99, 8'h01, 8'h02};
        vy = '{8'h34, 8'h0F, 8'h55, 8'h99, 8'h01, 8'h02};

        rst            = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        drive8(8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_sum", 32'(bus8.sum), 32'd0);
        chk("rst_cout", 32'(bus8.cout), 32'd0);
        chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);

        // single op: latency and one-cycle valid pulse
        send8(8'hFF, 8'h01, 1'b0);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            bus8.in_valid = 1'b0;
            if (bus8.out_valid && lat == 0) begin
                lat = n;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd4);
        @(posedge clk);
        #1;
        chk("valid_pulse", 32'(bus8.out_valid), 32'd0);
        drain8("drain_t1");

        send8(8'h5A, 8'h3C, 1'b0);
        idle8();
        drain8("drain_t2");

        // back-to-back results must arrive on consecutive cycles
        base = got8;
        send8(8'h00, 8'h00, 1'b1);
        send8(8'h80, 8'h80, 1'b0);
        send8(8'h7F, 8'h01, 1'b0);
        idle8();
        repeat (3) @(negedge clk);
        #3;
        chk("b2b_count", 32'(got8 - base), 32'd3);
        drain8("drain_t3");

        // downstream stall with continuous offers
        acc  = 0;
        base = got8;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus8.out_ready = 1'b0;
            drive8(vx[i], vy[i], 1'b0);
            bus8.in_valid = 1'b1;
            #1;
            if (bus8.in_ready) begin
                q8.push_back(model(W8, {8'd0, vx[i]}, {8'd0, vy[i]}, 1'b0));
                acc++;
            end
        end
        chk("stall_accepted", 32'(acc), 32'd4);
        chk("stall_in_ready", 32'(bus8.in_ready), 32'd0);
        @(negedge clk);
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        drain8("drain_t4");
        chk("stall_delivered", 32'(got8 - base), 32'd4);

        // reset with three operations in flight
        base = got8;
        send8(8'h11, 8'h22, 1'b1);
        send8(8'h40, 8'h40, 1'b0);
        send8(8'hC3, 8'h5A, 1'b1);
        @(negedge clk);
        rst           = 1'b1;
        bus8.in_valid = 1'b0;
        q8.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("midrst_sum", 32'(bus8.sum), 32'd0);
        chk("midrst_cout", 32'(bus8.cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(bus8.in_ready), 32'd1);
        repeat (8) @(negedge clk);
        #3;
        chk("midrst_no_stale", 32'(got8 - base), 32'd0);

        t = 0;
        while (!done13 && t < 30000) begin
            @(negedge clk);
            t++;
        end
        if (!done13) begin
            checks++;
            fails++;
            $display("FAIL done13_timeout: random WIDTH=13 run did not complete");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/prefix_sum_pipe.md
Name: prefix_sum_pipe

Overview:
Consumer end of the per-bit input cell interface (g = x&y, p = x|y, h = x^y).
- Takes WIDTH-wide g/p/h vectors plus carry-in.
- Resolves carries through a registered Kogge-Stone prefix network.
- Emits sum and carry-out.
- Sits after the bank of input cells in the adder datapath.
- Valid/ready handshake on both sides; fully pipelined, one operation per cycle.

Parameters:
WIDTH, 8, operand width in bits (>=1)
LEVELS, $clog2(WIDTH), prefix levels; derived, not overridden

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  g_in/p_in/h_in/cin valid
in_ready  output  1  block accepts input this cycle
g_in  input  WIDTH  per-bit generate (x&y)
p_in  input  WIDTH  per-bit propagate (x|y)
h_in  input  WIDTH  per-bit half-sum (x^y)
cin  input  1  carry into bit 0
out_valid  output  1  sum/cout valid
out_ready  input  1  downstream accepts output
sum  output  WIDTH  h ^ carries
cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset: all stage valid bits = 0, out_valid = 0, sum = 0, cout = 0. Data registers are also cleared to 0.
- Transfer rule: a transfer occurs on a clock edge when valid && ready are both high on that side.
- Stall: global stall = out_valid && !out_ready. in_ready = !stall. All pipeline registers hold when stalled.
- Input conditioning (stage 0, combinational on accept):
  - G0[0] = g_in[0] | (p_in[0] & cin); P0[0] = p_in[0].
  - Other bits pass through unchanged.
- Prefix level k (k = 1..LEVELS), distance d = 2^(k-1):
  - For i >= d: G[i] = G'[i] | (P'[i] & G'[i-d]); P[i] = P'[i] & P'[i-d].
  - For i < d: G and P pass through.
  - h and valid are carried alongside.
  - Registered at the end of each level.
- Sum stage (registered into the output register):
  - carry c[0] = cin; c[i] = G[i-1].
  - sum[i] = h[i] ^ c[i]; cout = G[WIDTH-1].
- Latency: LEVELS+1 cycles from accept to out_valid with no stall. WIDTH=8 gives 4 cycles. WIDTH=1 gives 1 cycle.
- Throughput: 1 result/cycle while out_ready = 1. A bubble (in_valid = 0) propagates as an invalid slot. out_valid is deasserted for that slot only.
- Simultaneous accept and drain in the same cycle is permitted and does not stall.
- Reset mid-operation: all in-flight operations are discarded. out_valid = 0 on the next cycle. in_ready = 1 on the cycle after reset deasserts.
- Input consistency: g_in must be a subset of p_in and h_in = p_in & ~g_in. Inconsistent inputs give undefined sum but must not corrupt the handshake.
- Output stability: sum/cout/out_valid are held stable while out_valid && !out_ready.

Optional Feature:
Macro PREFIX_SUM_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = c[WIDTH-1] ^ cout, the two's-complement overflow.
  - Registered with sum; reset 0; held under stall.
- Undefined: port absent; no extra logic.

Decomposition:
- Package prefix_pkg: clog2 helper function, the default WIDTH constant, and typedef gp_t (struct of g, p bits).
- Sub-module prefix_cell:
  - Combinational black cell with inputs (g_hi, p_hi, g_lo, p_lo) and outputs (g, p).
  - Instantiated per bit per level.
  - A gray cell is the same module with p unused.

Test Plan:
1. x=0xFF, y=0x01 (g=0x01, p=0xFF, h=0xFE), cin=0, out_ready=1 -> after 4 cycles sum=0x00, cout=1, out_valid pulses 1 cycle.
2. x=0x5A, y=0x3C (g=0x18, p=0x7E, h=0x66), cin=0 -> sum=0x96, cout=0; with PREFIX_SUM_OVF_EN, ovf=1.
3. Back-to-back: 0x00+0x00 cin=1, 0x80+0x80 cin=0, 0x7F+0x01 cin=0 on consecutive cycles -> sums 0x01/0x00/0x80, couts 0/1/0 on consecutive cycles starting at cycle 4.
4. out_ready=0 for 6 cycles with in_valid=1 -> in_ready drops once out_valid=1. Held sum is unchanged. Releasing out_ready gives 4 results in order with no loss or duplication.
5. Assert rst for 1 cycle with 3 operations in flight -> out_valid=0, sum=0, cout=0 next cycle. No stale result emerges afterward.
6. Random 10k operands, WIDTH=8 and WIDTH=13, random in_valid/out_ready -> every result equals x+y+cin, delivered in order.
